// File: rtl/datamem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : datamem_arbiter
// Description : Round-robin arbiter sharing one data-memory BRAM port between
//               the CPU data bus (port 0) and a DMA/debug master (port 1).
//               Outstanding reads are tracked in an in-order route FIFO so
//               each read response returns to the port that issued it.
// Revision    : 1.0 - initial release
// ============================================================================
module datamem_arbiter #(
  parameter int DATAMEM_DEPTH   = 8192,
  parameter int MAX_OUTSTANDING = 4,
  localparam int AW = $clog2(DATAMEM_DEPTH),
  localparam int PW = $clog2(MAX_OUTSTANDING),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rstf,
  // port 0 (CPU data bus)
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic [AW-1:0] r0_addr,
  input  logic [31:0]   r0_wdata,
  input  logic [3:0]    r0_mask,
  input  logic          r0_we,
  output logic [31:0]   r0_rdata,
  output logic          r0_rvalid,
  // port 1 (DMA / debug)
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic [AW-1:0] r1_addr,
  input  logic [31:0]   r1_wdata,
  input  logic [3:0]    r1_mask,
  input  logic          r1_we,
  output logic [31:0]   r1_rdata,
  output logic          r1_rvalid,
  // BRAM side
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_mask,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_rvalid,
  // status
  output logic [CW-1:0] outstanding,
  output logic          err_unexpected
);

  logic                       rr;          // port favoured on the next conflict
  logic                       lock_valid;  // a stalled grant is being held
  logic                       lock_port;
  logic [MAX_OUTSTANDING-1:0] route;       // issuing port ID per read slot
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [CW-1:0]              count;

  logic elig0, elig1, full, pop, push, xfer;
  logic gnt_valid, gnt_port;

  // A response pops the head only if a read is actually tracked; the slot it
  // frees is usable by a new read in the same cycle.
  assign pop   = mem_rvalid && (count != '0);
  assign full  = (count == CW'(MAX_OUTSTANDING)) && !pop;
  assign elig0 = r0_valid && (r0_we || !full);
  assign elig1 = r1_valid && (r1_we || !full);

  // Grant selection: hold a stalled grant, otherwise round-robin on conflict.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_port  = 1'b0;
    if (lock_valid && (lock_port ? elig1 : elig0)) begin
      gnt_valid = 1'b1;
      gnt_port  = lock_port;
    end else if (elig0 && elig1) begin
      gnt_valid = 1'b1;
      gnt_port  = rr;
    end else if (elig0) begin
      gnt_valid = 1'b1;
      gnt_port  = 1'b0;
    end else if (elig1) begin
      gnt_valid = 1'b1;
      gnt_port  = 1'b1;
    end
  end

  // No command leaves the block while reset is asserted.
  assign mem_valid = gnt_valid && rstf;
  assign mem_addr  = gnt_port ? r1_addr  : r0_addr;
  assign mem_wdata = gnt_port ? r1_wdata : r0_wdata;
  assign mem_mask  = gnt_port ? r1_mask  : r0_mask;
  assign mem_we    = gnt_port ? r1_we    : r0_we;
  assign r0_ready  = mem_valid && !gnt_port && mem_ready;
  assign r1_ready  = mem_valid &&  gnt_port && mem_ready;

  assign xfer        = mem_valid && mem_ready;
  assign push        = xfer && !mem_we;
  assign outstanding = count;

  // Round-robin pointer and stall lock.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      rr         <= 1'b0;
      lock_valid <= 1'b0;
      lock_port  <= 1'b0;
    end else if (xfer) begin
      rr         <= ~gnt_port;
      lock_valid <= 1'b0;
    end else if (mem_valid) begin
      lock_valid <= 1'b1;
      lock_port  <= gnt_port;
    end else begin
      lock_valid <= 1'b0;
    end
  end

  // Route FIFO: push the issuing port on read transfer, pop on response.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      route  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        route[wr_ptr] <= gnt_port;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered response steering plus the sticky unexpected-response flag.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      r0_rvalid      <= 1'b0;
      r1_rvalid      <= 1'b0;
      r0_rdata       <= '0;
      r1_rdata       <= '0;
      err_unexpected <= 1'b0;
    end else begin
      r0_rvalid <= pop && !route[rd_ptr];
      r1_rvalid <= pop &&  route[rd_ptr];
      if (pop && !route[rd_ptr]) begin
        r0_rdata <= mem_rdata;
      end
      if (pop && route[rd_ptr]) begin
        r1_rdata <= mem_rdata;
      end
      if (mem_rvalid && (count == '0)) begin
        err_unexpected <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_datamem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_datamem_arbiter
// Description : Self-checking bench for datamem_arbiter with an in-order BRAM
//               model and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datamem_arbiter;
  localparam int AW = 13;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          rstf;
  logic          r0_valid, r0_ready, r0_we, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [31:0]   r0_wdata, r0_rdata;
  logic [3:0]    r0_mask;
  logic          r1_valid, r1_ready, r1_we, r1_rvalid;
  logic [AW-1:0] r1_addr;
  logic [31:0]   r1_wdata, r1_rdata;
  logic [3:0]    r1_mask;
  logic          mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_mask;
  logic [OW-1:0] outstanding;
  logic          err_unexpected;

  datamem_arbiter #(.DATAMEM_DEPTH(8192), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rstf(rstf),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_mask(r0_mask), .r0_we(r0_we), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_mask(r1_mask), .r1_we(r1_we), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .outstanding(outstanding), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct { int port; logic [31:0] data; int cyc; } sb_t;
  typedef struct { int due; logic [31:0] data; } bq_t;
  sb_t sb[$];
  bq_t bq[$];

  bit          bram_auto = 1'b1;
  bit          bram_hold = 1'b0;
  bit          var_lat   = 1'b0;
  int          last_due  = 0;
  int          m_lat, m_due;
  logic        man_rvalid = 1'b0;
  logic [31:0] man_rdata  = '0;

  function automatic logic [31:0] data_of(input logic [AW-1:0] a);
    return {8'hA5, 11'd0, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // BRAM model: capture accepted reads mid-cycle, answer in order after latency.
  always @(negedge clk) begin
    if (rstf && mem_valid && mem_ready && !mem_we) begin
      m_lat = var_lat ? int'($urandom_range(5, 2)) : 1;
      m_due = cyc + m_lat;
      if (m_due <= last_due) m_due = last_due + 1;
      last_due = m_due;
      bq.push_back('{m_due, data_of(mem_addr)});
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    if (!bram_auto) begin
      mem_rvalid = man_rvalid;
      mem_rdata  = man_rdata;
    end else if (!bram_hold && bq.size() > 0 && bq[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = bq[0].data;
      void'(bq.pop_front());
    end else begin
      mem_rvalid = 1'b0;
    end
  end

  // Response monitor against the scoreboard.
  sb_t         mon_e;
  int          mon_p;
  logic [31:0] mon_d;
  always @(negedge clk) begin
    if (rstf && (r0_rvalid || r1_rvalid)) begin
      n_tests++;
      if (r0_rvalid && r1_rvalid) begin
        n_fail++;
        $display("FAIL resp_both: both rvalid high, required one (cycle %0d)", cyc);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: rvalid r0=%0b r1=%0b, required none (cycle %0d)",
                 r0_rvalid, r1_rvalid, cyc);
      end else begin
        mon_e = sb.pop_front();
        mon_p = r1_rvalid ? 1 : 0;
        mon_d = r1_rvalid ? r1_rdata : r0_rdata;
        if (mon_p != mon_e.port || mon_d !== mon_e.data || (mon_e.cyc >= 0 && mon_e.cyc != cyc)) begin
          n_fail++;
          $display("FAIL resp: port %0d data %0h cycle %0d, required port %0d data %0h cycle %0d",
                   mon_p, mon_d, cyc, mon_e.port, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic v0, input logic we0, input int a0,
                       input logic v1, input logic we1, input int a1, input logic rdy);
    r0_valid = v0; r0_we = we0; r0_addr = AW'(a0);
    r1_valid = v1; r1_we = we1; r1_addr = AW'(a1);
    mem_ready = rdy;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    rstf = 1'b0;
    bq.delete();
    sb.delete();
    last_due = 0;
    repeat (2) @(posedge clk);
    #1 rstf = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int k = 0;
    while ((sb.size() > 0 || bq.size() > 0) && k < max_cyc) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
    mid();
    check(name, 64'(sb.size() + bq.size()), 64'd0);
  endtask

  typedef struct {
    logic v0, we0, v1, we1, rdy;
    logic ev, er0, er1, ewe;
    int   gp;
  } vec_t;
  vec_t tbl[10];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int p;
    r0_wdata = 32'hDEADBEEF; r0_mask = 4'hF;
    r1_wdata = 32'h12345678; r1_mask = 4'h3;
    mem_rvalid = 1'b0; mem_rdata = '0;
    idle();

    // reset state, with a request presented during reset
    rstf = 1'b0;
    drive(1, 0, 'h10, 0, 0, 0, 1);
    #3;
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_err", 64'(err_unexpected), 64'd0);
    check("rst_rvalid", 64'({r0_rvalid, r1_rvalid}), 64'd0);
    check("rst_rdata", {r0_rdata, r1_rdata}, 64'd0);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    idle();
    do_reset();

    //            v0 we0 v1 we1 rdy  ev er0 er1 ewe gp
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
    tbl[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0};

    for (int i = 0; i < 10; i++) begin
      cyc_start();
      drive(tbl[i].v0, tbl[i].we0, 'h10, tbl[i].v1, tbl[i].we1, 'h20, tbl[i].rdy);
      mid();
      check($sformatf("vec%0d_handshake", i), 64'({mem_valid, r0_ready, r1_ready}),
            64'({tbl[i].ev, tbl[i].er0, tbl[i].er1}));
      if (tbl[i].ev) begin
        check($sformatf("vec%0d_fields", i), {mem_we, 3'd0, mem_addr, mem_wdata, mem_mask, 12'd0},
              (tbl[i].gp == 0) ? {tbl[i].ewe, 3'd0, AW'('h10), 32'hDEADBEEF, 4'hF, 12'd0}
                               : {tbl[i].ewe, 3'd0, AW'('h20), 32'h12345678, 4'h3, 12'd0});
      end
      if (i == 1) check("write_no_outstanding", 64'(outstanding), 64'd0);
      if (tbl[i].er0 && !tbl[i].we0) sb.push_back('{0, data_of(AW'('h10)), cyc + 2});
      if (tbl[i].er1 && !tbl[i].we1) sb.push_back('{1, data_of(AW'('h20)), cyc + 2});
    end
    cyc_start(); idle();
    wait_drain("table_drain", 20);

    // alternating reads from both ports, 1-cycle BRAM
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc_start();
      drive(1, 0, 'h004, 1, 0, 'h008, 1);
      mid();
      p = i % 2;
      check($sformatf("alt%0d_grant", i), 64'({r0_ready, r1_ready}), (p == 0) ? 64'd2 : 64'd1);
      sb.push_back('{p, data_of(AW'((p == 0) ? 'h004 : 'h008)), cyc + 2});
    end
    cyc_start(); idle();
    wait_drain("alt_drain", 20);
    check("rdata_hold", {r0_rdata, r1_rdata}, {data_of(AW'('h004)), data_of(AW'('h008))});

    // stall: grant held on port 0 although round-robin now favours port 1
    cyc_start(); drive(1, 1, 'h030, 0, 0, 0, 1);
    mid(); check("stall_pre_write", 64'(r0_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      cyc_start(); drive(1, 0, 'h00C, 0, 0, 0, 0);
      mid(); check($sformatf("stall%0d", i), 64'({mem_valid, r0_ready, mem_addr}), 64'({1'b1, 1'b0, AW'('h00C)}));
    end
    cyc_start(); drive(1, 0, 'h00C, 1, 0, 'h01C, 0);
    mid(); check("stall_lock", 64'({mem_addr, r1_ready}), 64'({AW'('h00C), 1'b0}));
    cyc_start(); drive(1, 0, 'h00C, 1, 0, 'h01C, 1);
    mid(); check("stall_accept0", 64'({r0_ready, r1_ready}), 64'd2);
    sb.push_back('{0, data_of(AW'('h00C)), cyc + 2});
    cyc_start(); drive(0, 0, 0, 1, 0, 'h01C, 1);
    mid(); check("stall_then1", 64'({r1_ready, mem_addr}), 64'({1'b1, AW'('h01C)}));
    sb.push_back('{1, data_of(AW'('h01C)), cyc + 2});
    cyc_start(); idle();
    wait_drain("stall_drain", 20);

    // route FIFO full: reads blocked, writes pass, push+pop at full
    bram_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc_start(); drive(1, 0, 'h100 + i, 0, 0, 0, 1);
      mid();
      check($sformatf("fill%0d", i), 64'({r0_ready, outstanding}), 64'({1'b1, OW'(i)}));
      sb.push_back('{0, data_of(AW'('h100 + i)), -1});
    end
    cyc_start(); drive(1, 0, 'h104, 1, 1, 'h040, 1);
    mid();
    check("full_block", 64'({r0_ready, r1_ready, mem_we, outstanding}), 64'({1'b0, 1'b1, 1'b1, OW'(4)}));
    cyc_start(); bram_hold = 1'b0; drive(1, 0, 'h104, 0, 0, 0, 1);
    mid();
    check("full_pushpop", 64'({r0_ready, outstanding}), 64'({1'b1, OW'(4)}));
    sb.push_back('{0, data_of(AW'('h104)), -1});
    cyc_start(); idle();
    mid(); check("full_after_pushpop", 64'(outstanding), 64'd4);
    wait_drain("full_drain", 30);

    // unexpected response, sticky error, asynchronous reset
    check("err_clear", 64'(err_unexpected), 64'd0);
    bram_auto = 1'b0;
    cyc_start(); man_rvalid = 1'b1; man_rdata = 32'hBAD0BAD0;
    cyc_start(); man_rvalid = 1'b0;
    mid();
    check("err_set", 64'({err_unexpected, r0_rvalid, r1_rvalid}), 64'({1'b1, 1'b0, 1'b0}));
    bram_auto = 1'b1; bram_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc_start(); drive(1, 0, 'h300 + i, 0, 0, 0, 1);
      mid(); check($sformatf("err_rd%0d", i), 64'(r0_ready), 64'd1);
    end
    cyc_start(); idle();
    mid();
    check("err_sticky", 64'({err_unexpected, outstanding}), 64'({1'b1, OW'(2)}));
    #2 rstf = 1'b0;
    drive(1, 0, 'h310, 0, 0, 0, 1);
    #1;
    check("async_rst", 64'({err_unexpected, outstanding, mem_valid}), 64'({1'b0, OW'(0), 1'b0}));
    bq.delete(); sb.delete(); last_due = 0; bram_hold = 1'b0;
    idle();
    do_reset();

    // interleaved reads 0,1,1,0 with variable in-order latency
    var_lat = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p = (i == 1 || i == 2) ? 1 : 0;
      cyc_start();
      if (p == 0) drive(1, 0, 'h200 + 'h10 * i, 0, 0, 0, 1);
      else        drive(0, 0, 0, 1, 0, 'h200 + 'h10 * i, 1);
      mid();
      check($sformatf("var%0d_grant", i), 64'({r0_ready, r1_ready}), (p == 0) ? 64'd2 : 64'd1);
      sb.push_back('{p, data_of(AW'('h200 + 'h10 * i)), -1});
    end
    cyc_start(); idle();
    wait_drain("var_drain", 60);
    var_lat = 1'b0;
    check("final_outstanding", 64'(outstanding), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
